// File: rtl/dct_pkg.sv
// Shared constants and state encoding for the 8x8 DCT transpose path.
package dct_pkg;

   localparam int DW    = 24;
   localparam int N     = 8;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      PRIME = 2'd1,
      DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/transpose_ctrl.sv
// Transpose controller: writes a block row-major into an external registered RAM,
// then reads it back column-major with a ready/valid handshake on both sides.
module transpose_ctrl
   import dct_pkg::*;
#(
   parameter int DW    = dct_pkg::DW,
   parameter int N     = dct_pkg::N,
   parameter int DEPTH = dct_pkg::DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic          frame_done,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_we,
   input  logic [DW-1:0] ram_dout
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   // Element k of the drain order sits at row k%N, column k/N of the stored block.
   function automatic logic [AW-1:0] col_major(input logic [AW-1:0] k);
      return AW'((int'(k) % N) * N + int'(k) / N);
   endfunction

   state_e        state_q, state_d;
   logic [AW-1:0] wr_cnt_q, wr_cnt_d;
   logic [AW-1:0] rd_cnt_q, rd_cnt_d;
   logic          frame_last_q, frame_last_d;
   logic [AW-1:0] rd_cnt_inc;

   assign rd_cnt_inc = rd_cnt_q + 1'b1;
   assign ram_din    = in_data;
   assign out_data   = ram_dout;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d      = state_q;
      wr_cnt_d     = wr_cnt_q;
      rd_cnt_d     = rd_cnt_q;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      ram_we       = 1'b0;
      ram_addr     = wr_cnt_q;
      frame_done   = 1'b0;

      unique case (state_q)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               ram_we   = 1'b1;
               wr_cnt_d = wr_cnt_q + 1'b1;
               if (wr_cnt_q == LAST) begin
                  state_d = PRIME;
               end
            end
         end
         PRIME: begin
            ram_addr = col_major('0);
            rd_cnt_d = '0;
            state_d  = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            // Without a consume, re-read the same word so out_data stays put.
            ram_addr  = col_major(rd_cnt_q);
            if (out_ready) begin
               ram_addr = col_major(rd_cnt_inc);
               rd_cnt_d = rd_cnt_inc;
               if (frame_last_q) begin
                  frame_done = 1'b1;
                  rd_cnt_d   = '0;
                  state_d    = FILL;
               end
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase

      if (rst) begin
         in_ready   = 1'b0;
         out_valid  = 1'b0;
         ram_we     = 1'b0;
         frame_done = 1'b0;
      end

      frame_last_d = (state_d == DRAIN) && (rd_cnt_d == LAST);
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
      if (rst) begin
         state_q      <= FILL;
         wr_cnt_q     <= '0;
         rd_cnt_q     <= '0;
         frame_last_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_cnt_q     <= wr_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         frame_last_q <= frame_last_d;
      end
   end

endmodule

// File: tb/tb_transpose_ctrl.sv
// Bench for transpose_ctrl paired with a 64x24 registered RAM whose output floats during writes.
module tb_transpose_ctrl;
   import dct_pkg::*;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready = 1'b0;
   logic          frame_done;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          ram_we;
   wire  [DW-1:0] ram_dout;

   always #5 clk = ~clk;

   transpose_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .frame_done (frame_done),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .ram_we     (ram_we),
      .ram_dout   (ram_dout)
   );

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rdata_q;
   logic          rd_ok_q = 1'b0;

   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_din;
         rd_ok_q       <= 1'b0;
      end else begin
         rdata_q <= mem[ram_addr];
         rd_ok_q <= 1'b1;
      end
   end

   assign ram_dout = rd_ok_q ? rdata_q : 'z;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_order [DEPTH];

   localparam logic [DW-1:0] JUNK = 24'hABCDEF;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Write may only happen while the controller is filling.
   always @(negedge clk) begin
      if (!rst && dut.state_q != FILL) begin
         n_checks++;
         if (ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL ram_we_outside_fill: got %0d, expected 0 (t=%0t)", ram_we, $time);
         end
      end
   end

   task automatic feed(input int base, input bit gap, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         in_data   = DW'(base + i);
         out_ready = 1'b1;
         #1;
         check("fill_ready", 32'(in_ready), 32'd1);
         check("fill_ovalid", 32'(out_valid), 32'd0);
         check("fill_we", 32'(ram_we), 32'd1);
         check("fill_addr", 32'(ram_addr), 32'(i));
         check("fill_din", 32'(ram_din), 32'(base + i));
         if (gap && i < n - 1) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = JUNK;
            #1;
            check("gap_ready", 32'(in_ready), 32'd1);
            check("gap_we", 32'(ram_we), 32'd0);
         end
      end
   endtask

   task automatic prime_cycle();
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = JUNK;
      #1;
      check("prime_ready", 32'(in_ready), 32'd0);
      check("prime_ovalid", 32'(out_valid), 32'd0);
      check("prime_we", 32'(ram_we), 32'd0);
      check("prime_addr", 32'(ram_addr), 32'd0);
      check("prime_done", 32'(frame_done), 32'd0);
   endtask

   task automatic drain(input int base, input int stall_at, input int stall_len, input int stop_at);
      int  k = 0;
      int  stalled = 0;
      bit  rdy;
      while (k < stop_at) begin
         @(negedge clk);
         rdy       = !(k == stall_at && stalled < stall_len);
         out_ready = rdy;
         in_valid  = 1'b1;
         in_data   = JUNK;
         #1;
         check("drain_ovalid", 32'(out_valid), 32'd1);
         check("drain_data", 32'(out_data), 32'(base + exp_order[k]));
         check("drain_ready", 32'(in_ready), 32'd0);
         check("drain_we", 32'(ram_we), 32'd0);
         check("drain_done", 32'(frame_done), 32'(rdy && k == DEPTH - 1));
         if (rdy) k++;
         else     stalled++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = JUNK;
      #1;
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_ovalid", 32'(out_valid), 32'd0);
      check("rst_we", 32'(ram_we), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      check("post_rst_ready", 32'(in_ready), 32'd1);
      check("post_rst_ovalid", 32'(out_valid), 32'd0);
      check("post_rst_we", 32'(ram_we), 32'd0);
      check("post_rst_addr", 32'(ram_addr), 32'd0);
   endtask

   typedef struct {
      string name;
      int    base;
      bit    gap;
      int    stall_at;
      int    stall_len;
   } scen_t;

   scen_t scen [5];

   initial begin
      // Column-major drain order: walk columns, and within each column walk rows.
      begin
         int idx = 0;
         for (int c = 0; c < N; c++) begin
            for (int r = 0; r < N; r++) begin
               exp_order[idx] = r * N + c;
               idx++;
            end
         end
      end

      scen[0] = '{name: "plain",     base: 0,    gap: 1'b0, stall_at: -1, stall_len: 0};
      scen[1] = '{name: "gapped_in", base: 4000, gap: 1'b1, stall_at: -1, stall_len: 0};
      scen[2] = '{name: "stall_k10", base: 0,    gap: 1'b0, stall_at: 10, stall_len: 5};
      scen[3] = '{name: "b2b_a",     base: 5000, gap: 1'b0, stall_at: -1, stall_len: 0};
      scen[4] = '{name: "b2b_b",     base: 6000, gap: 1'b0, stall_at: -1, stall_len: 0};

      // Reset held for two edges; outputs must be quiet while rst is high.
      @(negedge clk);
      #1;
      check("init_ready", 32'(in_ready), 32'd0);
      check("init_ovalid", 32'(out_valid), 32'd0);
      check("init_we", 32'(ram_we), 32'd0);
      check("init_done", 32'(frame_done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("init_fill_ready", 32'(in_ready), 32'd1);
      check("init_addr", 32'(ram_addr), 32'd0);

      for (int s = 0; s < 5; s++) begin
         feed(scen[s].base, scen[s].gap, DEPTH);
         prime_cycle();
         drain(scen[s].base, scen[s].stall_at, scen[s].stall_len, DEPTH);
      end

      // Hand-checked stall: element 10 lives at address 0x11 and must hold for all 5 cycles.
      feed(0, 1'b0, DEPTH);
      prime_cycle();
      drain(0, -1, 0, 10);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         out_ready = 1'b0;
         #1;
         check("hold_data", 32'(out_data), 32'd17);
         check("hold_done", 32'(frame_done), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check("resume_k10", 32'(out_data), 32'd17);
      @(negedge clk);
      #1;
      check("resume_k11", 32'(out_data), 32'd25);
      @(negedge clk);
      #1;
      check("resume_k12", 32'(out_data), 32'd33);
      do_reset();

      // Reset mid-fill, then a fresh block.
      feed(500, 1'b0, 30);
      do_reset();
      feed(1000, 1'b0, DEPTH);
      prime_cycle();
      drain(1000, -1, 0, DEPTH);

      // Reset mid-drain, then a fresh block.
      feed(2000, 1'b0, DEPTH);
      prime_cycle();
      drain(2000, -1, 0, 20);
      do_reset();
      feed(3000, 1'b0, DEPTH);
      prime_cycle();
      drain(3000, -1, 0, DEPTH);

      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("final_ready", 32'(in_ready), 32'd1);
      check("final_ovalid", 32'(out_valid), 32'd0);
      check("final_done", 32'(frame_done), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/transpose_ctrl.md
TRANSPOSE_CTRL -- requirements
Module: transpose_ctrl

Interface
REQ-001 Parameters: DW=24, data width; N=8, block dimension; DEPTH=64, RAM words (N*N).
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 in_valid  in  1  row-major coefficient present on in_data.
REQ-005 in_data  in  DW  coefficient from row-DCT stage.
REQ-006 in_ready  out  1  controller accepts in_data this cycle.
REQ-007 out_valid  out  1  column-major coefficient present on out_data.
REQ-008 out_data  out  DW  coefficient to column-DCT stage.
REQ-009 out_ready  in  1  downstream accepts out_data this cycle.
REQ-010 frame_done  out  1  one-cycle pulse, last coefficient of a block consumed.
REQ-011 ram_addr  out  6  RAM address.
REQ-012 ram_din  out  DW  RAM write data.
REQ-013 ram_we  out  1  RAM write enable; high=write, low=read.
REQ-014 ram_dout  in  DW  RAM read data; registered, 1-cycle latency, valid only while ram_we=0, high-Z otherwise.

Function
REQ-015 States: FILL, PRIME, DRAIN; held in a registered state variable.
REQ-016 FILL: in_ready=1, out_valid=0; handshake = in_valid & in_ready.
REQ-017 FILL handshake: ram_we=1, ram_addr=wr_cnt, ram_din=in_data, wr_cnt increments; no handshake: ram_we=0.
REQ-018 wr_cnt is 6 bits; the handshake at wr_cnt=63 moves to PRIME next cycle, wr_cnt wraps to 0.
REQ-019 Column-major map: element k maps to ram_addr = {k[2:0], k[5:3]}, i.e. row=k%8, col=k/8.
REQ-020 PRIME lasts exactly one cycle: in_ready=0, ram_we=0, ram_addr=map(0), out_valid=0; next state DRAIN, rd_cnt=0.
REQ-021 DRAIN: in_ready=0, ram_we=0, out_valid=1, out_data=ram_dout (combinational passthrough).
REQ-022 DRAIN, out_ready=1: element rd_cnt is consumed; ram_addr=map(rd_cnt+1); rd_cnt increments.
REQ-023 DRAIN, out_ready=0: ram_addr=map(rd_cnt), so the RAM re-reads the same word and out_data is held stable.
REQ-024 out_ready-to-ram_addr is a permitted combinational path.
REQ-025 Consumption at rd_cnt=63: frame_done=1 that cycle; next state FILL, rd_cnt=0; ram_addr don't-care that cycle, but ram_we=0.
REQ-026 Latency: last input handshake at cycle t -> PRIME at t+1 -> first out_valid at t+2, carrying element (0,0).
REQ-027 Throughput: 64 input beats + 1 PRIME cycle + 64 output beats per block with no stalls; fill and drain never overlap.
REQ-028 ram_we shall never be 1 outside FILL.
REQ-029 Inputs are ignored outside FILL (in_ready=0).

Reset
REQ-030 rst=1 at a clock edge: state=FILL, wr_cnt=0, rd_cnt=0, frame_done=0.
REQ-031 While rst=1: in_ready=0, out_valid=0, ram_we=0.
REQ-032 Reset mid-FILL or mid-DRAIN discards the partial block; RAM contents are not cleared; the next block starts at address 0.

Structure
REQ-033 Shared package dct_pkg holds DW, N, DEPTH, the address width (6) and the state encoding {FILL, PRIME, DRAIN}.
REQ-034 No sub-module inside transpose_ctrl; the 64x24 RAM is instantiated beside it at the parent level and connected through the ram_* ports.
REQ-035 RTL holds only the FSM, the two 6-bit counters, the address mux and the frame_done register.

Verification
REQ-036 Bench pairs transpose_ctrl with the 64x24 registered RAM model (tri-state dout).
REQ-037 Scenario 1: in_data=i for i=0..63, in_valid=1, out_ready=1 -> outputs 0,8,16,...,56,1,9,...,63; out_valid first at t+2; frame_done exactly on the 63 beat.
REQ-038 Scenario 2: in_valid toggled 1,0 every cycle -> only 64 handshakes written; output order same as scenario 1.
REQ-039 Scenario 3: out_ready=0 for 5 cycles at k=10 -> out_data holds value 17 (addr 0x11) for those cycles, then resumes 25,33,...
REQ-040 Scenario 4: rst=1 after 30 input beats, then a full new block of value 1000+i -> outputs 1000,1008,...; no stale data.
REQ-041 Scenario 5: rst=1 during DRAIN at k=20 -> next cycle in_ready=1, out_valid=0, ram_we=0; a subsequent block drains correctly.
REQ-042 Scenario 6: two back-to-back blocks -> in_ready=0 from PRIME through the final drain beat; an assertion confirms ram_we=0 whenever state!=FILL.
